// File: rtl/pipelined_n_bit_adder_pkg.sv
// Shared definitions for the pipelined N-bit adder: operation encodings and
// the per-stage chunk width derivation.
package pipelined_n_bit_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits handled by each pipeline stage; a zero stage count falls back to the
    // full width so that the legality check in the top can still elaborate.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/pipelined_n_bit_adder_chunk_stage.sv
// adder_chunk_stage: one CHUNK-bit slice of the carry chain, with its sum,
// carry and valid registers; everything holds while adv_i is low.
module adder_chunk_stage #(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             carry_o,
    output logic             valid_o
);

    logic [CHUNK-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             valid_d, valid_q;

    always_comb begin
        {carry_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};
        valid_d          = valid_i;
    end

    // NOTE: state is written with <= so every stage samples its predecessor's
    // pre-edge value; the hold when adv_i is low is an enable, not a latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (adv_i) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_n_bit_adder.sv
// pipelined_n_bit_adder: WIDTH-bit add/subtract whose carry ripples through
// STAGES registered chunks, with valid/ready flow control and a global stall.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVERFLOW_EN.
module pipelined_n_bit_adder
    import pipelined_n_bit_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             carry_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] answer,
    output logic             carry_out
`ifdef PIPE_ADDER_OVERFLOW_EN
   ,output logic             overflow
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_n_bit_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic             c_cond;

    // Per-stage inputs: word carrying finished low chunks plus raw high A chunks.
    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic             c_in    [STAGES];
    logic             v_in    [STAGES];
    logic [CHUNK-1:0] sum_s   [STAGES];
    logic             carry_s [STAGES];
    logic             valid_s [STAGES];
    logic [WIDTH-1:0] word_q  [STAGES];
    logic [WIDTH-1:0] bop_q   [STAGES];
    logic [WIDTH-1:0] word    [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign b_cond = (op_sub == OP_SUB) ? ~input2 : input2;
    assign c_cond = (op_sub == OP_SUB) ? 1'b1 : carry_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k] = input1;
            assign b_in[k] = b_cond;
            assign c_in[k] = c_cond;
            assign v_in[k] = in_valid;
        end else begin : g_body
            assign a_in[k] = word[k-1];
            assign b_in[k] = bop_q[k-1];
            assign c_in[k] = carry_s[k-1];
            assign v_in[k] = valid_s[k-1];
        end

        adder_chunk_stage #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv_i   (adv),
            .valid_i (v_in[k]),
            .a_i     (a_in[k][k*CHUNK +: CHUNK]),
            .b_i     (b_in[k][k*CHUNK +: CHUNK]),
            .carry_i (c_in[k]),
            .sum_o   (sum_s[k]),
            .carry_o (carry_s[k]),
            .valid_o (valid_s[k])
        );
    end

    // Skew registers: everything except the stage's own chunk travels here.
    // NOTE: data registers are reset as well, so answer reads 0 out of reset
    // and no X can leak through a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
                bop_q[k]  <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= a_in[k];
                bop_q[k]  <= b_in[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            word[k]                   = word_q[k];
            word[k][k*CHUNK +: CHUNK] = sum_s[k];
        end
    end

    assign answer    = word[STAGES-1];
    assign carry_out = carry_s[STAGES-1];
    assign out_valid = valid_s[STAGES-1];

`ifdef PIPE_ADDER_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;

    // Operand signs captured alongside the top chunk so overflow aligns with answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (adv) begin
            a_msb_q <= a_in[STAGES-1][WIDTH-1];
            b_msb_q <= b_in[STAGES-1][WIDTH-1];
        end
    end

    assign overflow = (a_msb_q == b_msb_q) && (answer[WIDTH-1] != a_msb_q);
`endif

endmodule
